// File: rtl/traffic_ctrl_if.sv
// rtl/traffic_ctrl_if.sv - timer handshake between the light sequencer and the down-counter
//
// Purpose : groups the start/load/done signals exchanged with the down-counter timer.
// Signals : count_start  sequencer -> timer, start request (held while a phase is timed)
//           count_value  sequencer -> timer, 5-bit load value, stable while count_start=1
//           count_done   timer -> sequencer, one-cycle done pulse
// Modports: master = sequencer side, slave = timer side
interface traffic_ctrl_if;
  logic       count_start;
  logic [4:0] count_value;
  logic       count_done;

  modport master (output count_start, output count_value, input count_done);
  modport slave  (input count_start, input count_value, output count_done);
endinterface

// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - intersection light sequencer driving the down-counter timer
//
// Purpose : sequences NS/EW vehicle lights, a latched pedestrian walk phase and an
//           emergency all-red override; each timed phase is measured by the external timer.
// Ports   : clk            clock, rising edge
//           rst_n          asynchronous active-low reset
//           tmr            timer handshake (count_start/count_value out, count_done in)
//           ped_req_i      pedestrian button, level or pulse
//           emergency_i    level, forces all-red while high
//           ns_light_o     NS lamp: 00 red, 01 yellow, 10 green
//           ew_light_o     EW lamp, same encoding
//           ped_walk_o     walk lamp
//           ped_pending_o  latched pedestrian request not yet served
module traffic_ctrl #(
  parameter logic [4:0] T_GREEN  = 5'd20,
  parameter logic [4:0] T_YELLOW = 5'd4,
  parameter logic [4:0] T_ALLRED = 5'd2,
  parameter logic [4:0] T_WALK   = 5'd10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  traffic_ctrl_if.master        tmr,
  input  logic                  ped_req_i,
  input  logic                  emergency_i,
  output logic [1:0]            ns_light_o,
  output logic [1:0]            ew_light_o,
  output logic                  ped_walk_o,
  output logic                  ped_pending_o
);

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    PED_WALK  = 3'd6,
    EMERGENCY = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [4:0] value_q, value_d;
  logic       pend_q, pend_d;
  logic [1:0] ns_q, ns_d;
  logic [1:0] ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       adv;
  logic       changed;

  // A done pulse only counts while the timer has actually been started; this
  // masks stale pulses in the restart gap and throughout EMERGENCY.
  assign adv = start_q & tmr.count_done;

  always_comb begin
    state_d = state_q;
    if (emergency_i) begin
      state_d = EMERGENCY;
    end else begin
      case (state_q)
        NS_GREEN:  if (adv) state_d = NS_YELLOW;
        NS_YELLOW: if (adv) state_d = ALLRED_1;
        ALLRED_1:  if (adv) state_d = EW_GREEN;
        EW_GREEN:  if (adv) state_d = EW_YELLOW;
        EW_YELLOW: if (adv) state_d = ALLRED_2;
        ALLRED_2:  if (adv) state_d = pend_q ? PED_WALK : NS_GREEN;
        PED_WALK:  if (adv) state_d = NS_GREEN;
        EMERGENCY: state_d = ALLRED_2;
        default:   state_d = ALLRED_2;
      endcase
    end
  end

  always_comb begin
    changed = (state_d != state_q);
    // Dropping start for the transition cycle lets the timer see a fresh
    // rising edge with the new load value already in place.
    start_d = (state_d != EMERGENCY) && !changed;

    value_d = value_q;
    ns_d    = LIGHT_RED;
    ew_d    = LIGHT_RED;
    walk_d  = 1'b0;
    case (state_d)
      NS_GREEN:  begin value_d = T_GREEN;  ns_d = LIGHT_GREEN;  end
      NS_YELLOW: begin value_d = T_YELLOW; ns_d = LIGHT_YELLOW; end
      ALLRED_1:  value_d = T_ALLRED;
      EW_GREEN:  begin value_d = T_GREEN;  ew_d = LIGHT_GREEN;  end
      EW_YELLOW: begin value_d = T_YELLOW; ew_d = LIGHT_YELLOW; end
      ALLRED_2:  value_d = T_ALLRED;
      PED_WALK:  begin value_d = T_WALK;   walk_d = 1'b1;       end
      default:   value_d = value_q;
    endcase

    // Entering the walk phase serves the request, even one arriving that cycle.
    if (state_d == PED_WALK && state_q != PED_WALK) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | ped_req_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED_2;
      start_q <= 1'b0;
      value_q <= T_ALLRED;
      pend_q  <= 1'b0;
      ns_q    <= LIGHT_RED;
      ew_q    <= LIGHT_RED;
      walk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      value_q <= value_d;
      pend_q  <= pend_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  assign tmr.count_start = start_q;
  assign tmr.count_value = value_q;
  assign ns_light_o      = ns_q;
  assign ew_light_o      = ew_q;
  assign ped_walk_o      = walk_q;
  assign ped_pending_o   = pend_q;

endmodule
